// File: rtl/button_event_pkg.sv
// Shared event-type encoding for the button event capture block.
package button_event_pkg;

    typedef logic [1:0] evt_type_t;

    localparam evt_type_t EVT_PRESS   = 2'b00;
    localparam evt_type_t EVT_RELEASE = 2'b01;
    localparam evt_type_t EVT_LONG    = 2'b10;

endpackage

// File: rtl/button_event_capture_if.sv
// Valid/ready event stream carrying {index, type} toward the CPU-facing stage.
interface button_event_capture_if
    import button_event_pkg::*;
#(
    parameter int unsigned IDX_WIDTH = 2
) ();

    logic                 event_valid;
    logic                 event_ready;
    logic [IDX_WIDTH-1:0] event_index;
    evt_type_t            event_type;

    modport master (
        output event_valid,
        output event_index,
        output event_type,
        input  event_ready
    );

    modport slave (
        input  event_valid,
        input  event_index,
        input  event_type,
        output event_ready
    );

endinterface

// File: rtl/button_event_bit.sv
// Per-bit edge detector with sticky pending/overflow flags.
// Long-press counter present only when BUTTON_EVENT_LONG_PRESS_EN is defined.
module button_event_bit #(
    parameter int unsigned LONG_TIMEOUT = 1000000,
    parameter int unsigned LONG_WIDTH   = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic i_a,
    input  logic i_primed,
    input  logic i_ld_press,
    input  logic i_ld_release,
    input  logic i_ld_long,
    input  logic i_clr,
    output logic o_press_pend,
    output logic o_release_pend,
    output logic o_long_pend,
    output logic o_overflow
);

    logic r_prev;
    logic r_press_pend;
    logic r_release_pend;
    logic r_overflow;
    logic w_press;
    logic w_release;
    logic w_long;
    logic w_long_pend;
    logic w_ovf_hit;

    assign w_press   = i_primed &  i_a & ~r_prev;
    assign w_release = i_primed & ~i_a &  r_prev;

    // An edge onto a flag that stays pending (not leaving via the output) is lost.
    assign w_ovf_hit = (w_press   & r_press_pend   & ~i_ld_press)
                     | (w_release & r_release_pend & ~i_ld_release)
                     | (w_long    & w_long_pend    & ~i_ld_long);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev         <= 1'b0;
            r_press_pend   <= 1'b0;
            r_release_pend <= 1'b0;
            r_overflow     <= 1'b0;
        end else begin
            r_prev         <= i_a;
            r_press_pend   <= w_press   | (r_press_pend   & ~i_ld_press   & ~i_clr);
            r_release_pend <= w_release | (r_release_pend & ~i_ld_release & ~i_clr);
            if (i_clr)
                r_overflow <= 1'b0;
            else if (w_ovf_hit)
                r_overflow <= 1'b1;
        end
    end

`ifdef BUTTON_EVENT_LONG_PRESS_EN
    logic [LONG_WIDTH-1:0] r_cnt;
    logic                  r_armed;
    logic                  r_long_pend;

    // Armed only by a real press, so a button held through reset never goes long.
    assign w_long = r_armed & i_a & ~w_press & (r_cnt == LONG_WIDTH'(LONG_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt       <= '0;
            r_armed     <= 1'b0;
            r_long_pend <= 1'b0;
        end else begin
            if (w_press) begin
                r_cnt   <= '0;
                r_armed <= 1'b1;
            end else if (w_release) begin
                r_cnt   <= '0;
                r_armed <= 1'b0;
            end else if (r_armed && i_a && (r_cnt < LONG_WIDTH'(LONG_TIMEOUT))) begin
                r_cnt <= r_cnt + LONG_WIDTH'(1);
            end
            r_long_pend <= w_long | (r_long_pend & ~i_ld_long & ~i_clr);
        end
    end

    assign w_long_pend = r_long_pend;
`else
    logic w_unused;

    assign w_long      = 1'b0;
    assign w_long_pend = 1'b0;
    assign w_unused    = ^{i_ld_long, LONG_WIDTH'(LONG_TIMEOUT)};
`endif

    assign o_press_pend   = r_press_pend;
    assign o_release_pend = r_release_pend;
    assign o_long_pend    = w_long_pend;
    assign o_overflow     = r_overflow;

endmodule

// File: rtl/button_event_capture.sv
// Button event capture: per-bit edge flags, lowest-index-first event stream, masked irq.
// Optional long-press events enabled by BUTTON_EVENT_LONG_PRESS_EN.
module button_event_capture
    import button_event_pkg::*;
#(
    parameter int unsigned WIDTH        = 4,
    parameter int unsigned IDX_WIDTH    = 2,
    parameter string       POLARITY     = "HIGH",
    parameter int unsigned LONG_TIMEOUT = 1000000,
    parameter int unsigned LONG_WIDTH   = 20
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [WIDTH-1:0]       data_in,
    input  logic [WIDTH-1:0]       irq_mask,
    input  logic                   clr_valid,
    input  logic [WIDTH-1:0]       clr_mask,
    output logic [WIDTH-1:0]       overflow,
    output logic                   irq,
    button_event_capture_if.master evt
);

    localparam bit ACTIVE_HIGH = (POLARITY == "HIGH");

    logic [WIDTH-1:0]     w_a;
    logic [WIDTH-1:0]     w_press_pend;
    logic [WIDTH-1:0]     w_release_pend;
    logic [WIDTH-1:0]     w_long_pend;
    logic [WIDTH-1:0]     w_ld_press;
    logic [WIDTH-1:0]     w_ld_release;
    logic [WIDTH-1:0]     w_ld_long;
    logic                 w_load;
    logic                 w_found;
    logic [IDX_WIDTH-1:0] w_sel_idx;
    evt_type_t            w_sel_type;

    logic                 r_primed;
    logic                 r_valid;
    logic [IDX_WIDTH-1:0] r_index;
    evt_type_t            r_type;
    logic                 r_irq;

    assign w_a = ACTIVE_HIGH ? data_in : ~data_in;

    for (genvar g = 0; g < int'(WIDTH); g++) begin : g_bit
        button_event_bit #(
            .LONG_TIMEOUT (LONG_TIMEOUT),
            .LONG_WIDTH   (LONG_WIDTH)
        ) u_bit (
            .clk            (clk),
            .reset          (reset),
            .i_a            (w_a[g]),
            .i_primed       (r_primed),
            .i_ld_press     (w_ld_press[g]),
            .i_ld_release   (w_ld_release[g]),
            .i_ld_long      (w_ld_long[g]),
            .i_clr          (clr_valid & clr_mask[g]),
            .o_press_pend   (w_press_pend[g]),
            .o_release_pend (w_release_pend[g]),
            .o_long_pend    (w_long_pend[g]),
            .o_overflow     (overflow[g])
        );
    end

    assign w_load = ~r_valid | evt.event_ready;

    // Lowest index wins; within a bit: press, long, release.
    always_comb begin
        w_found      = 1'b0;
        w_sel_idx    = '0;
        w_sel_type   = EVT_PRESS;
        w_ld_press   = '0;
        w_ld_release = '0;
        w_ld_long    = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (!w_found) begin
                if (w_press_pend[i]) begin
                    w_found       = 1'b1;
                    w_sel_idx     = IDX_WIDTH'(i);
                    w_sel_type    = EVT_PRESS;
                    w_ld_press[i] = w_load;
                end else if (w_long_pend[i]) begin
                    w_found      = 1'b1;
                    w_sel_idx    = IDX_WIDTH'(i);
                    w_sel_type   = EVT_LONG;
                    w_ld_long[i] = w_load;
                end else if (w_release_pend[i]) begin
                    w_found         = 1'b1;
                    w_sel_idx       = IDX_WIDTH'(i);
                    w_sel_type      = EVT_RELEASE;
                    w_ld_release[i] = w_load;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_primed <= 1'b0;
            r_valid  <= 1'b0;
            r_index  <= '0;
            r_type   <= EVT_PRESS;
            r_irq    <= 1'b0;
        end else begin
            r_primed <= 1'b1;
            if (w_load) begin
                r_valid <= w_found;
                if (w_found) begin
                    r_index <= w_sel_idx;
                    r_type  <= w_sel_type;
                end
            end
            r_irq <= |((w_press_pend | w_release_pend | w_long_pend) & irq_mask);
        end
    end

    assign evt.event_valid = r_valid;
    assign evt.event_index = r_index;
    assign evt.event_type  = r_type;
    assign irq             = r_irq;

endmodule
